mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Load/store sequencer between the CPU execute stage and `memory_integrated`. It accepts one word-sized load or store request at a time over a valid/ready handshake and drives the virtual memory bus: `addressVirt`, `dataInVirt`, `wEnVirt`, `dataOutVirt`. It holds the bus stable for the synchronous BRAM/IO read latency, captures load data, and returns a registered response that is held until the CPU accepts it. Misaligned accesses are trapped here and never reach memory.

## Interface
- `READ_LATENCY`, default 1: cycles from address presented on the bus to `mem_dout` valid. Legal range 1–7.
- `ALIGN_CHECK`, default 1: 1 traps addresses with `[1:0] != 0`; 0 passes every address through unchecked.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high. Puts the block in IDLE immediately.
- `req_valid` in 1: request present.
- `req_ready` out 1: block can accept a request. Equals (state == IDLE).
- `req_write` in 1: 1 = store, 0 = load.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data.
- `resp_valid` out 1: response available.
- `resp_ready` in 1: CPU accepts the response.
- `resp_data` out 32: load data; 0 for stores and errors.
- `resp_err` out 1: misaligned access trapped.
- `mem_addr` out 32: connects to `addressVirt`.
- `mem_din` out 32: connects to `dataInVirt`.
- `mem_wen` out 1: connects to `wEnVirt`.
- `mem_dout` in 32: connects to `dataOutVirt`.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_valid` & `req_ready` → latch `req_addr`, `req_wdata` and `req_write` into `mem_addr`, `mem_din` and an internal write flag.
  - If `ALIGN_CHECK` and `req_addr[1:0] != 0`: go to RESP with `resp_err`=1 and `resp_data`=0. `mem_wen` stays 0.
  - Otherwise go to ISSUE.
- **ISSUE** (one cycle)
  - Bus shows the latched address and data.
  - `mem_wen` = 1 only in ISSUE and only for a store; it is never high in any other state.
  - Store → RESP with `resp_data`=0.
  - Load → WAIT, with the down-counter loaded to `READ_LATENCY`−1.
- **WAIT**
  - `mem_addr` is held.
  - When the counter reaches 0: register `mem_dout` into `resp_data` and go to RESP. Otherwise decrement the counter.
  - The counter is 3 bits wide and never wraps below 0.
- **RESP**
  - `resp_valid` = 1; `resp_data` and `resp_err` are held stable.
  - `resp_ready` → IDLE; `resp_valid` drops next cycle.
  - Without `resp_ready`, stay in RESP indefinitely.
- `mem_addr` and `mem_din` keep their last values outside ISSUE/WAIT; they are not cleared.
- `req_ready` is 0 in ISSUE, WAIT and RESP. Requests presented then are ignored, not queued.
- Reset, including mid-transaction:
  - State is forced to IDLE.
  - `resp_valid`, `resp_err`, `mem_wen` = 0.
  - `resp_data`, `mem_addr`, `mem_din` = 0; counter = 0.
  - An in-flight load is discarded without a response. A store whose ISSUE cycle was already clocked has been written.
  - `req_ready` reads 1 while reset is held.

## Timing
- Cycle numbering: cycle 0 is the handshake cycle in IDLE.
- **Store:**
  - ISSUE in cycle 1 (`mem_wen`=1).
  - `resp_valid` in cycle 2.
  - Minimum spacing between accepted stores: 3 cycles.
- **Load:**
  - ISSUE in cycle 1.
  - WAIT in cycles 2 … 1+`READ_LATENCY`; `mem_dout` is sampled at the end of the last WAIT cycle.
  - `resp_valid` in cycle 2+`READ_LATENCY` (3 for the default).
  - Minimum spacing between accepted loads: 3+`READ_LATENCY` cycles.
- **Misaligned:** `resp_valid` in cycle 1; no bus activity.
- **Responses:** a response is consumed on the cycle where `resp_valid` & `resp_ready` are both high. The next request can be accepted one cycle later.
- **Outputs:** all outputs except `req_ready` are registered. `req_ready` is decoded directly from the state register.

## Test plan
- **Store then load (`READ_LATENCY`=1, BRAM model).**
  - Store `0x0000_0010` ← `0xDEAD_BEEF`: `mem_wen` is high exactly in cycle 1 with `mem_addr`=`0x10`; `resp_valid` in cycle 2 with data 0.
  - Load `0x10`: `resp_valid` in cycle 3 with `resp_data`=`0xDEAD_BEEF` and `resp_err`=0.
- **Response backpressure.** Load completes with `resp_ready` held low for 5 cycles: `resp_valid` and `resp_data` stay stable and `req_ready` stays 0. Raise `resp_ready`: IDLE the next cycle.
- **Misaligned trap.**
  - Store to `0x13`: `resp_err`=1 in cycle 1; `mem_wen` never rises; memory at `0x10` is unchanged.
  - With `ALIGN_CHECK`=0 the same store drives `mem_wen` with `mem_addr`=`0x13`.
- **Latency parameter.** With `READ_LATENCY`=3, a memory model returning data 3 cycles after address: a load returns the correct word with `resp_valid` in cycle 5. Sampling one cycle early must fail against the model.
- **Reset mid-load.**
  - Assert `reset` during WAIT: outputs go to their reset values asynchronously and no response is emitted.
  - After deassert, `req_ready`=1 and a new load of `0x10` returns the correct data.
- **Ignored requests.** Hold `req_valid` high with changing addresses during ISSUE/WAIT/RESP: exactly one transaction per IDLE handshake, and the bus address never changes mid-transaction.

Source files
------------

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Brief   : Single-outstanding load/store sequencer driving the virtual memory
//           bus, with misaligned-access trapping and a registered response.
// Revision: 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int READ_LATENCY = 1,
    parameter int ALIGN_CHECK  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic        mem_wen,
    input  logic [31:0] mem_dout
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [2:0] C_WAIT_INIT   = 3'(READ_LATENCY - 1);
    localparam logic       C_ALIGN_CHECK = (ALIGN_CHECK != 0);

    state_t      state_q;
    logic        write_q;
    logic [2:0]  cnt_q;
    logic        resp_valid_q;
    logic        resp_err_q;
    logic [31:0] resp_data_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_din_q;
    logic        mem_wen_q;
    logic        w_misaligned;

    assign w_misaligned = C_ALIGN_CHECK && (req_addr[1:0] != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            write_q      <= 1'b0;
            cnt_q        <= 3'd0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= 32'd0;
            mem_addr_q   <= 32'd0;
            mem_din_q    <= 32'd0;
            mem_wen_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_valid) begin
                        mem_addr_q <= req_addr;
                        mem_din_q  <= req_wdata;
                        write_q    <= req_write;
                        if (w_misaligned) begin
                            // Trap straight to a response; the bus never strobes.
                            state_q      <= RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_data_q  <= 32'd0;
                        end else begin
                            state_q   <= ISSUE;
                            mem_wen_q <= req_write;
                        end
                    end
                end
                ISSUE: begin
                    mem_wen_q <= 1'b0;
                    if (write_q) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= 32'd0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= C_WAIT_INIT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd0) begin
                        state_q      <= RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= mem_dout;
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_wen    = mem_wen_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Brief   : Directed bench for mem_access_unit: default build, a 3-cycle read
//           latency build and a build with alignment checking disabled.
// Revision: 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_ready;

    logic        rv_a, rr_a, rsv_a, re_a, mw_a;
    logic [31:0] rd_a, ma_a, md_a, mo_a;
    logic        rv_b, rr_b, rsv_b, re_b, mw_b;
    logic [31:0] rd_b, ma_b, md_b, mo_b;
    logic        rv_c, rr_c, rsv_c, re_c, mw_c;
    logic [31:0] rd_c, ma_c, md_c, mo_c;

    logic [31:0] mem_a [0:15];
    logic [31:0] mem_b [0:15];
    logic [31:0] mem_c [0:15];
    logic [31:0] b1, b2;

    int n_vec = 0;
    int n_err = 0;
    int hs_a  = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.READ_LATENCY(1), .ALIGN_CHECK(1)) u_dut_a (
        .clk(clk), .reset(reset), .req_valid(rv_a), .req_ready(rr_a),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsv_a), .resp_ready(resp_ready), .resp_data(rd_a),
        .resp_err(re_a), .mem_addr(ma_a), .mem_din(md_a), .mem_wen(mw_a),
        .mem_dout(mo_a)
    );

    mem_access_unit #(.READ_LATENCY(3), .ALIGN_CHECK(1)) u_dut_b (
        .clk(clk), .reset(reset), .req_valid(rv_b), .req_ready(rr_b),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsv_b), .resp_ready(resp_ready), .resp_data(rd_b),
        .resp_err(re_b), .mem_addr(ma_b), .mem_din(md_b), .mem_wen(mw_b),
        .mem_dout(mo_b)
    );

    mem_access_unit #(.READ_LATENCY(1), .ALIGN_CHECK(0)) u_dut_c (
        .clk(clk), .reset(reset), .req_valid(rv_c), .req_ready(rr_c),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(rsv_c), .resp_ready(resp_ready), .resp_data(rd_c),
        .resp_err(re_c), .mem_addr(ma_c), .mem_din(md_c), .mem_wen(mw_c),
        .mem_dout(mo_c)
    );

    // Single-cycle BRAM models and a three-stage read pipeline model.
    always @(posedge clk) begin
        if (mw_a) mem_a[ma_a[5:2]] <= md_a;
        mo_a <= mem_a[ma_a[5:2]];
        if (mw_c) mem_c[ma_c[5:2]] <= md_c;
        mo_c <= mem_c[ma_c[5:2]];
        b1   <= mem_b[ma_b[5:2]];
        b2   <= b1;
        mo_b <= b2;
    end

    always @(posedge clk) begin
        if (!reset && rv_a && rr_a) hs_a <= hs_a + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        rv_a = 1'b1; req_write = 1'b0; req_addr = addr; req_wdata = 32'h0BAD_0BAD;
        chk({tag, " rdy0"}, 32'(rr_a), 32'd1);
        step();                                   // cycle 1: ISSUE
        rv_a = 1'b0;
        chk({tag, " wen1"}, 32'(mw_a), 32'd0);
        chk({tag, " addr1"}, ma_a, addr);
        step();                                   // cycle 2: WAIT
        chk({tag, " vld2"}, 32'(rsv_a), 32'd0);
        step();                                   // cycle 3: RESP
        chk({tag, " vld3"}, 32'(rsv_a), 32'd1);
        chk({tag, " data3"}, rd_a, exp);
        chk({tag, " err3"}, 32'(re_a), 32'd0);
    endtask

    task automatic release_resp();
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem_b[i] = 32'h1111_0000 + 32'(i);
        mem_b[4] = 32'hCAFE_F00D;
        reset = 1'b1; rv_a = 1'b0; rv_b = 1'b0; rv_c = 1'b0;
        req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;
        step(); step();
        chk("rst rdy", 32'(rr_a), 32'd1);
        chk("rst vld", 32'(rsv_a), 32'd0);
        chk("rst wen", 32'(mw_a), 32'd0);
        chk("rst addr", ma_a, 32'd0);
        chk("rst data", rd_a, 32'd0);
        reset = 1'b0;
        step();

        // Store 0x10 <- 0xDEADBEEF
        rv_a = 1'b1; req_write = 1'b1; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF;
        step();
        rv_a = 1'b0;
        chk("st wen1", 32'(mw_a), 32'd1);
        chk("st addr1", ma_a, 32'h10);
        chk("st din1", md_a, 32'hDEAD_BEEF);
        chk("st vld1", 32'(rsv_a), 32'd0);
        step();
        chk("st wen2", 32'(mw_a), 32'd0);
        chk("st vld2", 32'(rsv_a), 32'd1);
        chk("st data2", rd_a, 32'd0);
        chk("st err2", 32'(re_a), 32'd0);
        release_resp();
        chk("st idle vld", 32'(rsv_a), 32'd0);
        chk("st idle rdy", 32'(rr_a), 32'd1);

        // Load back, then hold the response for 5 cycles
        load_a("ld", 32'h10, 32'hDEAD_BEEF);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("bp vld", 32'(rsv_a), 32'd1);
            chk("bp data", rd_a, 32'hDEAD_BEEF);
            chk("bp rdy", 32'(rr_a), 32'd0);
        end
        release_resp();
        chk("bp idle rdy", 32'(rr_a), 32'd1);
        chk("bp idle vld", 32'(rsv_a), 32'd0);

        // Misaligned store is trapped
        rv_a = 1'b1; req_write = 1'b1; req_addr = 32'h13; req_wdata = 32'h1234_5678;
        step();
        rv_a = 1'b0;
        chk("mis vld1", 32'(rsv_a), 32'd1);
        chk("mis err1", 32'(re_a), 32'd1);
        chk("mis data1", rd_a, 32'd0);
        chk("mis wen1", 32'(mw_a), 32'd0);
        release_resp();
        chk("mis wen2", 32'(mw_a), 32'd0);
        load_a("mis reld", 32'h10, 32'hDEAD_BEEF);
        release_resp();

        // Same store with alignment checking disabled reaches the bus
        rv_c = 1'b1; req_write = 1'b1; req_addr = 32'h13; req_wdata = 32'h5555_AAAA;
        step();
        rv_c = 1'b0;
        chk("noal wen1", 32'(mw_c), 32'd1);
        chk("noal addr1", ma_c, 32'h13);
        step();
        chk("noal vld2", 32'(rsv_c), 32'd1);
        chk("noal err2", 32'(re_c), 32'd0);
        release_resp();

        // Three-cycle read latency
        rv_b = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        step();
        rv_b = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            chk("l3 early vld", 32'(rsv_b), 32'd0);
            step();
        end
        chk("l3 vld5", 32'(rsv_b), 32'd1);
        chk("l3 data5", rd_b, 32'hCAFE_F00D);
        chk("l3 err5", 32'(re_b), 32'd0);
        release_resp();

        // Reset asserted during WAIT
        rv_a = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wdata = 32'h7777_7777;
        step();
        rv_a = 1'b0;
        step();                                   // WAIT
        reset = 1'b1;
        #1;
        chk("rmid vld", 32'(rsv_a), 32'd0);
        chk("rmid addr", ma_a, 32'd0);
        chk("rmid din", md_a, 32'd0);
        chk("rmid data", rd_a, 32'd0);
        chk("rmid rdy", 32'(rr_a), 32'd1);
        step();
        reset = 1'b0;
        step();
        chk("rpost vld", 32'(rsv_a), 32'd0);
        chk("rpost rdy", 32'(rr_a), 32'd1);
        load_a("rpost ld", 32'h10, 32'hDEAD_BEEF);
        release_resp();

        // Requests held during a transaction are ignored
        begin
            int hs0;
            hs0 = hs_a;
            rv_a = 1'b1; req_write = 1'b0; req_addr = 32'h10;
            step();
            req_addr = 32'h20;
            chk("ign addr1", ma_a, 32'h10);
            chk("ign rdy1", 32'(rr_a), 32'd0);
            step();
            req_addr = 32'h24;
            chk("ign addr2", ma_a, 32'h10);
            step();
            req_addr = 32'h28;
            chk("ign vld3", 32'(rsv_a), 32'd1);
            chk("ign data3", rd_a, 32'hDEAD_BEEF);
            chk("ign addr3", ma_a, 32'h10);
            step();
            chk("ign addr4", ma_a, 32'h10);
            chk("ign vld4", 32'(rsv_a), 32'd1);
            rv_a = 1'b0;
            release_resp();
            chk("ign idle vld", 32'(rsv_a), 32'd0);
            chk("ign handshakes", 32'(hs_a - hs0), 32'd1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
